// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS main controller
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_ADDI_EXEC = 4'd8,
    S_ADDI_WB   = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JR        = 4'd12
  } state_e;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_A      = 2'b11;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;
  function automatic logic op_legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
  endfunction
endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: state to control-word decode; everything forced to 0 under reset
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  input  logic   rst,
  output ctrl_t  ctrl
);
  always_comb begin
    ctrl = '0;
    if (!rst)
      case (state)
        S_FETCH: begin
          ctrl.mem_read  = 1'b1;
          ctrl.alu_src_b = SRCB_4;
          ctrl.ir_write  = mem_ready;
          ctrl.pc_write  = mem_ready;
        end
        S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
        S_MEM_ADDR, S_ADDI_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          ctrl.mem_read = 1'b1;
          ctrl.i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          ctrl.mem_write = 1'b1;
          ctrl.i_or_d    = 1'b1;
        end
        S_MEM_WB: begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = 1'b1;
        end
        S_R_EXEC: begin
          ctrl.alu_src_a = 1'b1;
          ctrl.alu_op    = ALU_RTYPE;
        end
        S_R_WB: begin
          ctrl.reg_write = 1'b1;
          ctrl.reg_dst   = 1'b1;
        end
        S_ADDI_WB: ctrl.reg_write = 1'b1;
        S_BRANCH: begin
          ctrl.alu_src_a     = 1'b1;
          ctrl.alu_op        = ALU_SUB;
          ctrl.pc_write_cond = 1'b1;
          ctrl.pc_source     = PCS_ALUOUT;
        end
        S_JUMP: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_JUMP;
        end
        S_JR: begin
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCS_A;
        end
        default: ;
      endcase
  end
endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multi-cycle MIPS main FSM; state register and next-state logic
module mc_main_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic       jr_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [2:0] alu_op_o,
  output logic [1:0] pc_source_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);
  state_e state, state_nxt;
  ctrl_t  ctrl;
  always_ff @(posedge clk_i)
    state <= rst_i ? S_FETCH : state_nxt;
  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:     state_nxt = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE:    state_nxt = (op_i == OP_LW || op_i == OP_SW) ? S_MEM_ADDR :
                               op_i == OP_R    ? (jr_i ? S_JR : S_R_EXEC) :
                               op_i == OP_ADDI ? S_ADDI_EXEC :
                               op_i == OP_BEQ  ? S_BRANCH :
                               op_i == OP_J    ? S_JUMP : S_FETCH;
      S_MEM_ADDR:  state_nxt = op_i == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    state_nxt = mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:    state_nxt = mem_ready_i ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    state_nxt = S_R_WB;
      S_ADDI_EXEC: state_nxt = S_ADDI_WB;
      default:     state_nxt = S_FETCH;
    endcase
  end
  mc_ctrl_outdec u_outdec (
    .state     (state),
    .mem_ready (mem_ready_i),
    .rst       (rst_i),
    .ctrl      (ctrl)
  );
  assign pc_write_o      = ctrl.pc_write;
  assign pc_write_cond_o = ctrl.pc_write_cond;
  assign i_or_d_o        = ctrl.i_or_d;
  assign mem_read_o      = ctrl.mem_read;
  assign mem_write_o     = ctrl.mem_write;
  assign ir_write_o      = ctrl.ir_write;
  assign reg_dst_o       = ctrl.reg_dst;
  assign mem_to_reg_o    = ctrl.mem_to_reg;
  assign reg_write_o     = ctrl.reg_write;
  assign alu_src_a_o     = ctrl.alu_src_a;
  assign alu_src_b_o     = ctrl.alu_src_b;
  assign alu_op_o        = ctrl.alu_op;
  assign pc_source_o     = ctrl.pc_source;
  assign illegal_o       = !rst_i && state == S_DECODE && !op_legal(op_i);
  assign state_o         = state;
endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: directed cycle-by-cycle check of the main controller
module tb_mc_main_ctrl;
  logic       clk = 1'b0, rst_i = 1'b1, jr_i = 1'b0, mem_ready_i = 1'b1;
  logic [5:0] op_i = 6'b000000;
  logic       pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
  logic       reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;
  logic [17:0] ctl;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  mc_main_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .jr_i(jr_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .i_or_d_o(i_or_d_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .pc_source_o(pc_source_o), .illegal_o(illegal_o), .state_o(state_o)
  );
  assign ctl = {pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
                reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                pc_source_o, illegal_o};
  function automatic logic [17:0] mk(input logic pcw, pcc, iod, mr, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, input logic [2:0] aop,
                                     input logic [1:0] ps, input logic ill);
    return {pcw, pcc, iod, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ps, ill};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic [3:0] es, input logic [17:0] ec);
    @(negedge clk);
    chk({tag, "_state"}, {28'd0, state_o}, {28'd0, es});
    chk(tag, {14'd0, ctl}, {14'd0, ec});
    @(posedge clk);
    #1;
  endtask
  logic [17:0] f_rdy, f_wait, dec, dec_ill, ex_imm, r_ex, r_wb, m_rd, m_wr, m_wb, a_wb, br, jmp, jr;
  initial begin
    f_rdy   = mk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b000,2'b00,0);
    f_wait  = mk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b000,2'b00,0);
    dec     = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,0);
    dec_ill = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b000,2'b00,1);
    ex_imm  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b000,2'b00,0);
    r_ex    = mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0);
    r_wb    = mk(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,0);
    m_rd    = mk(0,0,1,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0);
    m_wr    = mk(0,0,1,0,1,0,0,0,0,0,2'b00,3'b000,2'b00,0);
    m_wb    = mk(0,0,0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,0);
    a_wb    = mk(0,0,0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,0);
    br      = mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b01,0);
    jmp     = mk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0);
    jr      = mk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b000,2'b11,0);
    for (int i = 0; i < 3; i++) step("reset", 4'd0, 18'd0);
    rst_i = 1'b0;
    step("r_fetch", 4'd0, f_rdy);
    step("r_dec", 4'd1, dec);
    step("r_exec", 4'd6, r_ex);
    step("r_wb", 4'd7, r_wb);
    op_i = 6'b100011;
    step("lw_fetch", 4'd0, f_rdy);
    step("lw_dec", 4'd1, dec);
    step("lw_addr", 4'd2, ex_imm);
    mem_ready_i = 1'b0;
    step("lw_wait1", 4'd3, m_rd);
    step("lw_wait2", 4'd3, m_rd);
    mem_ready_i = 1'b1;
    step("lw_rd", 4'd3, m_rd);
    step("lw_wb", 4'd4, m_wb);
    op_i = 6'b000100;
    step("beq_fetch", 4'd0, f_rdy);
    step("beq_dec", 4'd1, dec);
    step("beq_br", 4'd10, br);
    op_i = 6'b000000;
    jr_i = 1'b1;
    step("jr_fetch", 4'd0, f_rdy);
    step("jr_dec", 4'd1, dec);
    step("jr_jr", 4'd12, jr);
    op_i = 6'b111111;
    jr_i = 1'b0;
    step("ill_fetch", 4'd0, f_rdy);
    step("ill_dec", 4'd1, dec_ill);
    mem_ready_i = 1'b0;
    step("ill_after", 4'd0, f_wait);
    mem_ready_i = 1'b1;
    op_i = 6'b101011;
    step("sw_fetch", 4'd0, f_rdy);
    step("sw_dec", 4'd1, dec);
    step("sw_addr", 4'd2, ex_imm);
    mem_ready_i = 1'b0;
    step("sw_wait1", 4'd5, m_wr);
    step("sw_wait2", 4'd5, m_wr);
    rst_i = 1'b1;
    step("sw_rst", 4'd5, 18'd0);
    rst_i = 1'b0;
    mem_ready_i = 1'b1;
    op_i = 6'b000010;
    step("j_fetch", 4'd0, f_rdy);
    step("j_dec", 4'd1, dec);
    step("j_jump", 4'd11, jmp);
    op_i = 6'b001000;
    step("addi_fetch", 4'd0, f_rdy);
    step("addi_dec", 4'd1, dec);
    step("addi_exec", 4'd8, ex_imm);
    step("addi_wb", 4'd9, a_wb);
    step("addi_next", 4'd0, f_rdy);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Main control state machine for the multi-cycle MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath mux select and write strobe. It generates the 3-bit ALU operation class consumed by the ALU function decoder and takes back that decoder's jr flag. Instruction/data memory is variable-latency behind a ready handshake.

## Interface
Parameters: none (all encodings are fixed constants in the shared package).

- clk_i  in  1  rising-edge clock
- rst_i  in  1  synchronous, active-high reset
- op_i  in  6  IR[31:26]
- jr_i  in  1  jr flag from ALU function decoder (valid when op_i=000000)
- mem_ready_i  in  1  memory access completes this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if ALU zero
- i_or_d_o  out  1  memory address: 0=PC, 1=ALUOut
- mem_read_o / mem_write_o  out  1  memory strobes
- ir_write_o  out  1  IR load
- reg_dst_o  out  1  write reg: 0=rt, 1=rd
- mem_to_reg_o  out  1  write data: 0=ALUOut, 1=MDR
- reg_write_o  out  1  register file write
- alu_src_a_o  out  1  0=PC, 1=A
- alu_src_b_o  out  2  00=B, 01=4, 10=sign-ext imm, 11=imm<<2
- alu_op_o  out  3  000=add, 001=sub, 010=R-type (funct decoded)
- pc_source_o  out  2  00=ALU result, 01=ALUOut, 10=jump target, 11=A (jr)
- illegal_o  out  1  one-cycle pulse on unsupported opcode
- state_o  out  4  current state, debug

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP, JR.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00. Hold until mem_ready_i=1; in that cycle pulse ir_write and pc_write, go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut). Next: lw/sw→MEM_ADDR; R with jr_i=1→JR; R with jr_i=0→R_EXEC; addi→ADDI_EXEC; beq→BRANCH; j→JUMP; other→FETCH with illegal_o=1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; →MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready_i, then MEM_WB.
- MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready_i, then FETCH.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; →FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010; →R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; →FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000; →ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; →FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01; →FETCH.
- JUMP: pc_write=1, pc_source=10; JR: pc_write=1, pc_source=11; both →FETCH.
- Any output not listed for a state is 0.

## Timing
- State register updates on clk_i rising edge. Outputs are combinational from state, plus mem_ready_i for the FETCH strobes.
- Reset: state=FETCH (state_o=0). While rst_i=1, every strobe and illegal_o is 0 and all selects are 0. The first fetch starts in the cycle after rst_i falls.
- Reset mid-instruction (including during a memory wait) aborts the instruction. No write strobe fires in the reset cycle.
- Cycles with zero-wait memory (mem_ready_i tied high): R 4, addi 4, lw 5, sw 4, beq 3, j 3, jr 3. Each wait cycle adds 1 cycle in FETCH, MEM_RD or MEM_WR.
- pc_write and ir_write fire exactly once per fetch, in the cycle mem_ready_i=1.
- mem_read_o/mem_write_o stay asserted and the address stays stable throughout a wait.

## Structure
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode constants
  - ALUOp constants (shared with the ALU function decoder)
  - alu_src_b and pc_source select constants
- One sub-module, mc_ctrl_outdec: purely combinational state→control-word decode. The top level keeps the state register and the next-state logic.

## Test plan
- Reset held 3 cycles, then released, mem_ready_i=1 → all strobes 0 during reset. Then FETCH with mem_read_o=1, ir_write_o=1, pc_write_o=1 in the first post-reset cycle.
- R-type add (op=000000, jr_i=0), zero-wait → states FETCH, DECODE, R_EXEC, R_WB. alu_op_o=010 in R_EXEC; reg_write_o=1 with reg_dst_o=1 in cycle 4 only.
- lw with mem_ready_i low for 2 cycles in MEM_RD → 7 cycles total. mem_read_o=1 and i_or_d_o=1 held steady throughout; reg_write_o=1 with mem_to_reg_o=1 once.
- beq → BRANCH in cycle 3 with alu_op_o=001, pc_write_cond_o=1, pc_source_o=01. jr (op=0, jr_i=1) → JR with pc_write_o=1, pc_source_o=11.
- op=111111 → illegal_o pulses for 1 cycle in DECODE, then back to FETCH with no writes.
- rst_i asserted during a MEM_WR wait → next state FETCH, mem_write_o=0 in the reset cycle and no reg_write.
